// File: rtl/pcie_lane_enable_seq.sv
// pcie_lane_enable_seq: staged power-up/power-down of the four PCIe lane-group
// enables, with a bounded wait for link training and a latched fault state.
module pcie_lane_enable_seq #(
    parameter int unsigned STAGE_DELAY  = 256,
    parameter int unsigned LINK_TIMEOUT = 65535,
    parameter int unsigned CNT_W        = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic start,
    input  logic stop,
    input  logic link_up,
    output logic en0,
    output logic en1,
    output logic en2,
    output logic en3,
    output logic busy,
    output logic ready,
    output logic error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP_UP,
        S_WAIT_LINK,
        S_ACTIVE,
        S_RAMP_DOWN,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] LINK_LAST  = CNT_W'(LINK_TIMEOUT - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       en_q;
    logic             busy_q;
    logic             ready_q;
    logic             error_q;

    // Enables form a thermometer code, so the next step up or down is a shift.
    logic [3:0]       en_up_d;
    logic [3:0]       en_dn_d;
    logic [CNT_W-1:0] cnt_inc_d;
    logic             stage_done;
    logic             link_expired;
    logic             can_stop;

    assign en_up_d      = {en_q[2:0], 1'b1};
    assign en_dn_d      = {1'b0, en_q[3:1]};
    assign cnt_inc_d    = cnt_q + CNT_W'(1);
    assign stage_done   = (cnt_q == STAGE_LAST);
    assign link_expired = (cnt_q == LINK_LAST);
    assign can_stop     = (state_q == S_RAMP_UP) ||
                          (state_q == S_WAIT_LINK) ||
                          (state_q == S_ACTIVE);

    // Sequencer FSM; stop outranks link status, which outranks stage stepping.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            en_q    <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else if (stop && can_stop) begin
            // Drop the top group now; with only en0 left we are already done.
            en_q    <= en_dn_d;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            if (en_q[1]) begin
                state_q <= S_RAMP_DOWN;
                busy_q  <= 1'b1;
            end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_q <= S_RAMP_UP;
                        en_q    <= 4'b0001;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RAMP_UP: begin
                    if (stage_done) begin
                        en_q  <= en_up_d;
                        cnt_q <= '0;
                        if (en_q[2]) begin
                            state_q <= S_WAIT_LINK;
                        end
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                S_WAIT_LINK: begin
                    if (link_up) begin
                        state_q <= S_ACTIVE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (link_expired) begin
                        state_q <= S_FAULT;
                        cnt_q   <= '0;
                        en_q    <= '0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                S_ACTIVE: begin
                    if (!link_up) begin
                        state_q <= S_FAULT;
                        en_q    <= '0;
                        ready_q <= 1'b0;
                        error_q <= 1'b1;
                    end
                end
                S_RAMP_DOWN: begin
                    if (stage_done) begin
                        en_q  <= en_dn_d;
                        cnt_q <= '0;
                        if (!en_q[1]) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                S_FAULT: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        error_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    en_q    <= '0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                end
            endcase
        end
    end

    assign en0   = en_q[0];
    assign en1   = en_q[1];
    assign en2   = en_q[2];
    assign en3   = en_q[3];
    assign busy  = busy_q;
    assign ready = ready_q;
    assign error = error_q;

endmodule

// File: tb/tb_pcie_lane_enable_seq.sv
// tb_pcie_lane_enable_seq: directed scenarios plus a randomized run checked
// against a time-arithmetic reference model of the lane sequencer.
module tb_pcie_lane_enable_seq;

    localparam int SD = 4;
    localparam int LT = 20;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_WAIT = 2;
    localparam int M_ACT  = 3;
    localparam int M_DOWN = 4;
    localparam int M_FLT  = 5;

    logic CLK;
    logic RST_N;
    logic start;
    logic stop;
    logic link_up;
    logic en0, en1, en2, en3;
    logic busy, ready, error;

    logic [3:0] en_v;
    logic [2:0] st_v;
    assign en_v = {en3, en2, en1, en0};
    assign st_v = {busy, ready, error};

    int total;
    int bad;

    pcie_lane_enable_seq #(
        .STAGE_DELAY(SD),
        .LINK_TIMEOUT(LT),
        .CNT_W(8)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .start(start),
        .stop(stop),
        .link_up(link_up),
        .en0(en0),
        .en1(en1),
        .en2(en2),
        .en3(en3),
        .busy(busy),
        .ready(ready),
        .error(error)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [3:0] lv(int l);
        return 4'((1 << l) - 1);
    endfunction

    task automatic do_reset();
        RST_N = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        link_up = 1'b0;
        tick();
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        start = 1'b0;
        stop = 1'b0;
        link_up = 1'b0;
        RST_N = 1'b1;
        #2;
        RST_N = 1'b0;
        #1;
        total++;
        if (en_v !== 4'b0 || st_v !== 3'b0) begin
            bad++;
            $display("FAIL reset_async: en=%b st=%b want en=0000 st=000", en_v, st_v);
        end
        tick();
        total++;
        if (en_v !== 4'b0 || st_v !== 3'b0) begin
            bad++;
            $display("FAIL reset_hold: en=%b st=%b want en=0000 st=000", en_v, st_v);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        total++;
        if (en_v !== 4'b0 || st_v !== 3'b0) begin
            bad++;
            $display("FAIL reset_idle: en=%b st=%b want en=0000 st=000", en_v, st_v);
        end
    endtask

    // start at edge 0, link_up from edge 14; leaves the block in ACTIVE.
    task automatic run_nominal();
        int l;
        logic [2:0] es;
        for (int e = 0; e < 16; e++) begin
            start = (e == 0);
            stop = 1'b0;
            link_up = (e >= 14);
            tick();
            l = (e >= 12) ? 4 : e / SD + 1;
            es = {(e < 14), (e >= 14), 1'b0};
            total++;
            if (en_v !== lv(l)) begin
                bad++;
                $display("FAIL nom_en e=%0d: got %b want %b", e, en_v, lv(l));
            end
            total++;
            if (st_v !== es) begin
                bad++;
                $display("FAIL nom_st e=%0d: got %b want %b", e, st_v, es);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_nominal();
        do_reset();
        run_nominal();
    endtask

    // Orderly shutdown from ACTIVE, stop sampled at relative edge 0.
    task automatic test_shutdown();
        int l;
        logic [2:0] es;
        for (int j = 0; j < 14; j++) begin
            stop = (j == 0);
            link_up = 1'b1;
            tick();
            l = (j >= 12) ? 0 : 3 - j / SD;
            es = {(j < 12), 1'b0, 1'b0};
            total++;
            if (en_v !== lv(l) || st_v !== es) begin
                bad++;
                $display("FAIL shut j=%0d: en=%b st=%b want en=%b st=%b",
                         j, en_v, st_v, lv(l), es);
            end
        end
        stop = 1'b0;
    endtask

    task automatic test_timeout();
        int l;
        logic [2:0] es;
        do_reset();
        for (int e = 0; e < 45; e++) begin
            start = (e == 0);
            stop = (e == 40);
            link_up = 1'b0;
            tick();
            l = (e >= 32) ? 0 : (e >= 12) ? 4 : e / SD + 1;
            es = {(e < 32), 1'b0, (e >= 32 && e < 40)};
            total++;
            if (en_v !== lv(l) || st_v !== es) begin
                bad++;
                $display("FAIL timeout e=%0d: en=%b st=%b want en=%b st=%b",
                         e, en_v, st_v, lv(l), es);
            end
        end
        stop = 1'b0;
    endtask

    // start held high; stop at 5..12, released at 13, then a lone-en0 stop at 14.
    task automatic test_early_stop();
        int lvt[15];
        logic [2:0] es;
        lvt = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0};
        do_reset();
        for (int e = 0; e < 15; e++) begin
            start = 1'b1;
            stop = (e >= 5 && e <= 12) || (e == 14);
            link_up = 1'b0;
            tick();
            es = {(lvt[e] > 0), 1'b0, 1'b0};
            total++;
            if (en_v !== lv(lvt[e]) || st_v !== es) begin
                bad++;
                $display("FAIL early e=%0d: en=%b st=%b want en=%b st=%b",
                         e, en_v, st_v, lv(lvt[e]), es);
            end
        end
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic test_link_loss();
        int l;
        logic [2:0] es;
        do_reset();
        for (int e = 0; e < 56; e++) begin
            start = (e == 0) || (e >= 52);
            stop = 1'b0;
            link_up = (e >= 13 && e < 50);
            tick();
            l = (e >= 50) ? 0 : (e >= 12) ? 4 : e / SD + 1;
            es = {(e <= 12), (e >= 13 && e < 50), (e >= 50)};
            total++;
            if (en_v !== lv(l) || st_v !== es) begin
                bad++;
                $display("FAIL linkloss e=%0d: en=%b st=%b want en=%b st=%b",
                         e, en_v, st_v, lv(l), es);
            end
        end
        start = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        total++;
        if (en_v !== 4'b0 || st_v !== 3'b0) begin
            bad++;
            $display("FAIL fault_clear: en=%b st=%b want en=0000 st=000", en_v, st_v);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (en_v !== 4'b0011 || st_v !== 3'b100) begin
            bad++;
            $display("FAIL pre_areset: en=%b st=%b want en=0011 st=100", en_v, st_v);
        end
        #2;
        RST_N = 1'b0;
        #1;
        total++;
        if (en_v !== 4'b0 || st_v !== 3'b0) begin
            bad++;
            $display("FAIL areset: en=%b st=%b want en=0000 st=000", en_v, st_v);
        end
        #2;
        RST_N = 1'b1;
        tick();
        total++;
        if (en_v !== 4'b0 || st_v !== 3'b0) begin
            bad++;
            $display("FAIL areset_idle: en=%b st=%b want en=0000 st=000", en_v, st_v);
        end
        run_nominal();
    endtask

    // Model: each mode remembers the edge it was entered on; enable levels
    // follow from elapsed time divided by the stage delay.
    task automatic test_random();
        int mode, t0, base, e, cur, l;
        logic [2:0] es;
        do_reset();
        mode = M_IDLE;
        t0 = 0;
        base = 0;
        link_up = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            start = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 24) == 0) link_up = ~link_up;
            tick();
            e = n - t0;
            case (mode)
                M_IDLE: if (start && !stop) begin mode = M_UP; t0 = n; end
                M_UP: begin
                    if (stop) begin
                        cur = 1 + (e - 1) / SD;
                        if (cur == 1) mode = M_IDLE;
                        else begin mode = M_DOWN; t0 = n; base = cur - 1; end
                    end else if (e == 3 * SD) begin
                        mode = M_WAIT; t0 = n;
                    end
                end
                M_WAIT: begin
                    if (stop) begin mode = M_DOWN; t0 = n; base = 3; end
                    else if (link_up) mode = M_ACT;
                    else if (e == LT) mode = M_FLT;
                end
                M_ACT: begin
                    if (stop) begin mode = M_DOWN; t0 = n; base = 3; end
                    else if (!link_up) mode = M_FLT;
                end
                M_DOWN: if (e == base * SD) mode = M_IDLE;
                default: if (stop) mode = M_IDLE;
            endcase
            e = n - t0;
            case (mode)
                M_UP: l = 1 + e / SD;
                M_WAIT, M_ACT: l = 4;
                M_DOWN: l = base - e / SD;
                default: l = 0;
            endcase
            es = {(mode == M_UP || mode == M_WAIT || mode == M_DOWN),
                  (mode == M_ACT), (mode == M_FLT)};
            total++;
            if (en_v !== lv(l) || st_v !== es) begin
                bad++;
                $display("FAIL rand n=%0d: en=%b st=%b want en=%b st=%b",
                         n, en_v, st_v, lv(l), es);
            end
        end
        start = 1'b0;
        stop = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_nominal();
        test_shutdown();
        test_timeout();
        test_early_stop();
        test_link_loss();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
